// File: rtl/vram_arbiter_if.sv
// Bus bundle between the video SRAM arbiter and its CPU, VPU and SRAM neighbours.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_rw;
  logic              cpu_cs;
  logic              cpu_halt;
  logic              cpu_ba;
  logic              vpu_hold;
  logic [ADDR_W-1:0] vpu_addr;
  logic              vpu_cs;
  logic [7:0]        vpu_data;
  logic              hold_ack;
  logic              timeout;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wdata;
  logic [7:0]        sram_rdata;
  logic              sram_ce_n;
  logic              sram_we_n;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rw, cpu_cs, cpu_ba,
    input  vpu_hold, vpu_addr, vpu_cs, sram_rdata,
    output cpu_rdata, cpu_halt, vpu_data, hold_ack, timeout,
    output sram_addr, sram_wdata, sram_ce_n, sram_we_n
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rw, cpu_cs, cpu_ba,
    output vpu_hold, vpu_addr, vpu_cs, sram_rdata,
    input  cpu_rdata, cpu_halt, vpu_data, hold_ack, timeout,
    input  sram_addr, sram_wdata, sram_ce_n, sram_we_n
  );
endinterface

// File: rtl/vram_arbiter.sv
// Time-shares the video SRAM between the CPU bus and the read-only VPU line-cache DMA,
// with CPU halt/drain, idle turnaround gaps on ownership changes and a sticky grant timeout.
module vram_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DRAIN_MAX   = 15,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_GRANT   = 4095
) (
  input  logic              clk,
  input  logic              rst,
  vram_arbiter_if.slave     bus
);
  localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX + 1) : 1;
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES + 1) : 1;
  localparam int GW = $clog2(MAX_GRANT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);
  localparam logic [GW-1:0] GRANT_LAST = GW'(MAX_GRANT);

  typedef enum logic [2:0] {
    S_CPU      = 3'd0,
    S_DRAIN    = 3'd1,
    S_TURN_IN  = 3'd2,
    S_GRANT    = 3'd3,
    S_TURN_OUT = 3'd4
  } state_e;

  state_e        state_q;
  logic [DW-1:0] drain_cnt_q;
  logic [TW-1:0] turn_cnt_q;
  logic [GW-1:0] grant_cnt_q;
  logic          cpu_halt_q;
  logic          hold_ack_q;
  logic          timeout_q;
  logic [7:0]    vpu_data_q;
  logic          drain_acc_s;

  assign bus.cpu_rdata = bus.sram_rdata;
  assign bus.cpu_halt  = cpu_halt_q;
  assign bus.hold_ack  = hold_ack_q;
  assign bus.timeout   = timeout_q;
  assign bus.vpu_data  = vpu_data_q;

  // Once the CPU reports bus-available it must not start new cycles; such accesses are dropped.
  assign drain_acc_s = bus.cpu_cs & ~bus.cpu_ba;

  // SRAM steering: CPU pass-through, VPU read-only, idle during turnaround and reset.
  always_comb begin
    bus.sram_addr  = bus.cpu_addr;
    bus.sram_wdata = bus.cpu_wdata;
    bus.sram_ce_n  = 1'b1;
    bus.sram_we_n  = 1'b1;
    if (rst) begin
      bus.sram_ce_n = 1'b1;
    end else begin
      case (state_q)
        S_CPU: begin
          bus.sram_ce_n = ~bus.cpu_cs;
          bus.sram_we_n = ~(bus.cpu_cs & ~bus.cpu_rw);
        end
        S_DRAIN: begin
          bus.sram_ce_n = ~drain_acc_s;
          bus.sram_we_n = ~(drain_acc_s & ~bus.cpu_rw);
        end
        S_GRANT: begin
          bus.sram_addr = bus.vpu_addr;
          bus.sram_ce_n = ~bus.vpu_cs;
        end
        default: begin
          bus.sram_ce_n = 1'b1;
        end
      endcase
    end
  end

  // Ownership FSM with registered halt/ack/timeout/data outputs; all counters saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CPU;
      drain_cnt_q <= '0;
      turn_cnt_q  <= '0;
      grant_cnt_q <= '0;
      cpu_halt_q  <= 1'b0;
      hold_ack_q  <= 1'b0;
      timeout_q   <= 1'b0;
      vpu_data_q  <= 8'h00;
    end else begin
      case (state_q)
        S_CPU: begin
          if (bus.vpu_hold) begin
            cpu_halt_q  <= 1'b1;
            drain_cnt_q <= '0;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!bus.vpu_hold) begin
            turn_cnt_q <= '0;
            state_q    <= S_TURN_OUT;
          end else if (bus.cpu_ba || drain_cnt_q == DRAIN_LAST) begin
            turn_cnt_q <= '0;
            state_q    <= S_TURN_IN;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        S_TURN_IN: begin
          if (turn_cnt_q == TURN_LAST) begin
            hold_ack_q  <= 1'b1;
            grant_cnt_q <= '0;
            state_q     <= S_GRANT;
          end else begin
            turn_cnt_q <= turn_cnt_q + 1'b1;
          end
        end
        S_GRANT: begin
          if (bus.vpu_cs) begin
            vpu_data_q <= bus.sram_rdata;
          end
          // A runaway grant is only flagged; the VPU keeps the bus until it lets go.
          if (!bus.vpu_hold) begin
            hold_ack_q <= 1'b0;
            turn_cnt_q <= '0;
            state_q    <= S_TURN_OUT;
          end else if (grant_cnt_q == GRANT_LAST) begin
            timeout_q <= 1'b1;
          end else begin
            grant_cnt_q <= grant_cnt_q + 1'b1;
          end
        end
        S_TURN_OUT: begin
          if (turn_cnt_q == TURN_LAST) begin
            cpu_halt_q <= 1'b0;
            state_q    <= S_CPU;
          end else begin
            turn_cnt_q <= turn_cnt_q + 1'b1;
          end
        end
        default: begin
          cpu_halt_q <= 1'b0;
          hold_ack_q <= 1'b0;
          state_q    <= S_CPU;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized self-checking bench for vram_arbiter: an SRAM model plus a shadow memory and
// arithmetic timing expectations (grant latency, turnaround, timeout) derived from the arbitration rules.
module tb_vram_arbiter;
  localparam int ADDR_W      = 16;
  localparam int DRAIN_MAX   = 15;
  localparam int TURN_CYCLES = 1;
  localparam int MAX_GRANT   = 4095;
  localparam int MEM_SIZE    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] mem    [0:MEM_SIZE-1];
  logic [7:0] shadow [0:MEM_SIZE-1];
  logic [7:0] vd_model;
  logic       to_model;

  vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DRAIN_MAX(DRAIN_MAX), .TURN_CYCLES(TURN_CYCLES), .MAX_GRANT(MAX_GRANT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seed_byte(input int a);
    return 8'((a * 37) ^ (a >> 5) ^ 8'h5D);
  endfunction

  // Asynchronous-read SRAM with a clocked write strobe.
  assign bus.sram_rdata = mem[bus.sram_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= seed_byte(i);
    end else if (!bus.sram_ce_n && !bus.sram_we_n) begin
      mem[bus.sram_addr] <= bus.sram_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bus.cpu_cs = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = a; bus.cpu_wdata = d;
    #1;
    check_eq("cpu_we", bus.sram_we_n, 1'b0);
    check_eq("cpu_ce", bus.sram_ce_n, 1'b0);
    check_eq("cpu_waddr", bus.sram_addr, a);
    step();
    shadow[a] = d;
    bus.cpu_cs = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a);
    bus.cpu_cs = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = a;
    #1;
    check_eq("cpu_rdata", bus.cpu_rdata, shadow[a]);
    check_eq("cpu_rd_we", bus.sram_we_n, 1'b1);
    step();
    bus.cpu_cs = 1'b0;
  endtask

  // Drop the request: TURN_CYCLES idle cycles with halt held, then the CPU owns the bus again.
  task automatic release_hold();
    bus.vpu_hold = 1'b0; bus.vpu_cs = 1'b0; bus.cpu_cs = 1'b1; bus.cpu_rw = 1'b1;
    for (int k = 1; k <= TURN_CYCLES + 1; k++) begin
      step();
      check_eq("rel_ack", bus.hold_ack, 1'b0);
      check_eq("rel_halt", bus.cpu_halt, k <= TURN_CYCLES);
      check_eq("rel_timeout", bus.timeout, to_model);
      check_eq("rel_vdata", bus.vpu_data, vd_model);
      if (k <= TURN_CYCLES) check_eq("turn_out_ce", bus.sram_ce_n, 1'b1);
    end
    check_eq("back_ce", bus.sram_ce_n, 1'b0);
    check_eq("back_rdata", bus.cpu_rdata, shadow[bus.cpu_addr]);
    bus.cpu_cs = 1'b0; bus.cpu_ba = 1'b0;
  endtask

  // One VPU bus request. cpu_ba rises before edge ba_dly+1 (edge 1 samples the request),
  // so the grant lands min(ba_dly, DRAIN_MAX) + TURN_CYCLES + 1 edges after the request.
  task automatic episode(input int ba_dly, input int len, input int drop_at, input bit rst_grant);
    int d;
    int ge;
    logic rcs;
    logic [ADDR_W-1:0] ra;
    d  = (ba_dly < DRAIN_MAX) ? ba_dly : DRAIN_MAX;
    ge = 1 + d + TURN_CYCLES;
    bus.cpu_cs = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = ADDR_W'($urandom); bus.cpu_ba = 1'b0;
    bus.vpu_cs = 1'b0; bus.vpu_hold = 1'b1;
    #1;
    check_eq("req_ce", bus.sram_ce_n, 1'b0);
    check_eq("req_halt", bus.cpu_halt, 1'b0);
    for (int n = 1; n <= ge; n++) begin
      step();
      bus.cpu_ba = (n >= ba_dly);
      #1;
      check_eq("wait_halt", bus.cpu_halt, 1'b1);
      check_eq("wait_ack", bus.hold_ack, n >= ge);
      if (n <= d) check_eq("drain_ce", bus.sram_ce_n, n >= ba_dly);
      else if (n < ge) check_eq("turn_in_ce", bus.sram_ce_n, 1'b1);
      if (n == drop_at) begin
        release_hold();
        return;
      end
    end
    // The halted CPU keeps trying to write 0x1234; the VPU side is read-only.
    bus.cpu_cs = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 16'h1234;
    for (int i = 1; i <= len; i++) begin
      rcs = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      ra  = (i == 1) ? 16'h1234 : ADDR_W'($urandom);
      bus.vpu_cs = rcs; bus.vpu_addr = ra; bus.cpu_wdata = 8'($urandom);
      #1;
      check_eq("grant_we", bus.sram_we_n, 1'b1);
      check_eq("grant_ce", bus.sram_ce_n, !rcs);
      check_eq("grant_addr", bus.sram_addr, ra);
      step();
      if (rcs) vd_model = shadow[ra];
      if (i > MAX_GRANT) to_model = 1'b1;
      check_eq("vpu_data", bus.vpu_data, vd_model);
      check_eq("timeout", bus.timeout, to_model);
      check_eq("grant_ack", bus.hold_ack, 1'b1);
    end
    if (rst_grant) begin
      rst = 1'b1; bus.vpu_hold = 1'b0; bus.vpu_cs = 1'b0;
      step();
      check_eq("rst_ack", bus.hold_ack, 1'b0);
      check_eq("rst_halt", bus.cpu_halt, 1'b0);
      check_eq("rst_timeout", bus.timeout, 1'b0);
      check_eq("rst_vdata", bus.vpu_data, 8'h00);
      check_eq("rst_ce", bus.sram_ce_n, 1'b1);
      check_eq("rst_we", bus.sram_we_n, 1'b1);
      rst = 1'b0; vd_model = 8'h00; to_model = 1'b0;
      bus.cpu_cs = 1'b0; bus.cpu_ba = 1'b0;
    end else begin
      release_hold();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int bd;
    int dd;
    int drop;
    rst = 1'b1; mem_init = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wdata = 8'h00; bus.cpu_rw = 1'b1; bus.cpu_cs = 1'b0;
    bus.cpu_ba = 1'b0; bus.vpu_hold = 1'b0; bus.vpu_addr = '0; bus.vpu_cs = 1'b0;
    vd_model = 8'h00; to_model = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) shadow[i] = seed_byte(i);
    step();
    step();
    mem_init = 1'b0;
    check_eq("reset_halt", bus.cpu_halt, 1'b0);
    check_eq("reset_ack", bus.hold_ack, 1'b0);
    check_eq("reset_timeout", bus.timeout, 1'b0);
    check_eq("reset_vdata", bus.vpu_data, 8'h00);
    check_eq("reset_ce", bus.sram_ce_n, 1'b1);
    check_eq("reset_we", bus.sram_we_n, 1'b1);
    rst = 1'b0;

    cpu_write(16'h1234, 8'h5A);
    cpu_read(16'h1234);

    // VPU strobes without a grant must not touch the SRAM or vpu_data.
    bus.vpu_cs = 1'b1; bus.vpu_addr = ADDR_W'($urandom);
    #1;
    check_eq("ungranted_ce", bus.sram_ce_n, 1'b1);
    step();
    check_eq("ungranted_vdata", bus.vpu_data, vd_model);
    bus.vpu_cs = 1'b0;

    episode(2, 4, 0, 1'b0);
    cpu_read(16'h1234);
    episode(100, 3, 0, 1'b0);
    episode(100, 0, 5, 1'b0);

    for (int r = 0; r < 10; r++) begin
      for (int w = 0; w < 3; w++) cpu_write(ADDR_W'($urandom), 8'($urandom));
      for (int w = 0; w < 2; w++) cpu_read(ADDR_W'($urandom));
      bd   = int'($urandom_range(1, 20));
      dd   = (bd < DRAIN_MAX) ? bd : DRAIN_MAX;
      drop = 0;
      if (dd >= 2 && $urandom_range(0, 2) == 0) drop = int'($urandom_range(1, dd - 1));
      episode(bd, int'($urandom_range(1, 10)), drop, 1'b0);
    end

    episode(3, MAX_GRANT + 1, 0, 1'b0);
    cpu_write(16'h0042, 8'hC3);
    cpu_read(16'h0042);
    check_eq("timeout_sticky", bus.timeout, to_model);
    episode(2, 3, 0, 1'b1);
    cpu_read(16'h0042);
    episode(4, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
